psk_demod: RTL

Coherent BPSK/QPSK demodulator on the 16.384 MHz domain; receive-side counterpart of the PSK modulator.
- Derotates received I/Q samples by the local carrier and integrates-and-dumps over 16-sample (1.024 Msym/s) windows aligned by DELAY_CNT.
- Slices each window to 1 or 2 bits and emits them as an AXIS byte stream to the 16.384 MHz RX FIFO.
- Carrier and timing recovery are upstream; this block only correlates, decides, and buffers.

---
 rtl/psk_pkg.sv | 20 ++
 rtl/psk_demod_if.sv | 27 ++
 rtl/psk_slicer.sv | 41 ++++
 rtl/psk_demod.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared constants and types for the PSK demodulator and its decision slicer.
package psk_pkg;

    localparam int unsigned SPS      = 16;
    localparam int unsigned BPSK_BIT = 1;

    // QPSK decision codes: 00 -> +I, 10 -> -I, 11 -> +Q, 01 -> -Q
    typedef enum logic [1:0] {
        SYM_00 = 2'b00,
        SYM_01 = 2'b01,
        SYM_10 = 2'b10,
        SYM_11 = 2'b11
    } qpsk_sym_t;

    // Product width plus 4 bits of growth for a 16-sample sum
    function automatic int unsigned acc_w(input int unsigned width);
        return 2 * width + 5;
    endfunction

endpackage

// File: rtl/psk_demod_if.sv
// AXIS byte-stream carrying decided symbols; soft outputs exist only with PSK_DEMOD_SOFT_EN.
interface psk_demod_if
    import psk_pkg::*;
#(
    parameter int unsigned BYTES = 1
`ifdef PSK_DEMOD_SOFT_EN
    , parameter int unsigned ACC_W = psk_pkg::acc_w(12)
`endif
);

    logic [BYTES*8-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               tuser;
`ifdef PSK_DEMOD_SOFT_EN
    logic signed [ACC_W-1:0] soft_I;
    logic signed [ACC_W-1:0] soft_Q;

    modport master (output tdata, tvalid, tlast, tuser, soft_I, soft_Q, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, soft_I, soft_Q, output tready);
`else
    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
`endif

endinterface

// File: rtl/psk_slicer.sv
// Combinational hard decision from integrated I/Q; shared with soft-decision and EVM blocks.
module psk_slicer
    import psk_pkg::*;
#(
    parameter int unsigned ACC_W = 29
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [ACC_W-1:0] acc_q,
    input  logic                    is_bpsk,
    output logic [1:0]              bits_c
);

    localparam int unsigned MAG_W = ACC_W + 1;

    logic             i_neg_c;
    logic             q_neg_c;
    logic [MAG_W-1:0] mag_i_c;
    logic [MAG_W-1:0] mag_q_c;

    // One extra bit keeps the magnitude of the most negative value exact
    always_comb begin
        i_neg_c = acc_i[ACC_W-1];
        q_neg_c = acc_q[ACC_W-1];
        mag_i_c = i_neg_c ? -MAG_W'(acc_i) : MAG_W'(acc_i);
        mag_q_c = q_neg_c ? -MAG_W'(acc_q) : MAG_W'(acc_q);
    end

    // Ties between axes resolve to the I axis
    always_comb begin
        bits_c = SYM_00;
        if (is_bpsk) begin
            bits_c           = 2'b00;
            bits_c[BPSK_BIT] = ~i_neg_c;
        end else if (mag_i_c >= mag_q_c) begin
            bits_c = i_neg_c ? SYM_10 : SYM_00;
        end else begin
            bits_c = q_neg_c ? SYM_01 : SYM_11;
        end
    end

endmodule

// File: rtl/psk_demod.sv
// Coherent BPSK/QPSK integrate-and-dump demodulator with a 1-deep AXIS output register.
// Optional soft outputs (dumped accumulators) are enabled by PSK_DEMOD_SOFT_EN.
module psk_demod
    import psk_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned BYTES = 1
) (
    input  logic                    clk_16M384,
    input  logic                    rst_16M384,
    input  logic signed [WIDTH-1:0] in_I,
    input  logic signed [WIDTH-1:0] in_Q,
    input  logic                    in_vld,
    input  logic                    in_last,
    input  logic                    in_is_bpsk,
    input  logic signed [WIDTH-1:0] carrier_I,
    input  logic signed [WIDTH-1:0] carrier_Q,
    input  logic [3:0]              DELAY_CNT,
    psk_demod_if.master             data,
    output logic                    ovf,
    output logic                    out_clk_1M024
);

    localparam int unsigned ACC_W   = acc_w(WIDTH);
    localparam int unsigned PROD_W  = 2 * WIDTH + 1;
    localparam int unsigned TDATA_W = BYTES * 8;
    localparam int unsigned LEN_W   = 5;

    typedef enum logic {
        WIN_IDLE,
        WIN_ACC
    } win_state_t;

    logic [3:0]               cnt;
    logic                     start_c;
    logic signed [PROD_W-1:0] y_i;
    logic signed [PROD_W-1:0] y_q;
    logic                     s1_start;
    logic                     s1_vld;
    logic                     s1_last;
    logic                     s1_bpsk;
    win_state_t               state;
    win_state_t               state_d;
    logic                     load_c;
    logic                     add_c;
    logic                     dump_c;
    logic [LEN_W-1:0]         win_len;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     sym_vld;
    logic                     sym_last;
    logic                     sym_bpsk;
    logic [1:0]               bits_c;
    logic                     dec_c;
    logic                     blocked_c;

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) cnt <= 4'd0;
        else            cnt <= cnt + 4'd1;
    end

    assign out_clk_1M024 = cnt[3];
    assign start_c       = (cnt == DELAY_CNT);

    // Stage 1: derotation by the local carrier, window-start tag travels alongside
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            y_i      <= '0;
            y_q      <= '0;
            s1_start <= 1'b0;
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_bpsk  <= 1'b0;
        end else begin
            y_i      <= in_vld ? PROD_W'(in_I) * PROD_W'(carrier_I) + PROD_W'(in_Q) * PROD_W'(carrier_Q) : '0;
            y_q      <= in_vld ? PROD_W'(in_Q) * PROD_W'(carrier_I) - PROD_W'(in_I) * PROD_W'(carrier_Q) : '0;
            s1_start <= start_c;
            s1_vld   <= in_vld;
            s1_last  <= in_last;
            s1_bpsk  <= in_is_bpsk;
        end
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) state <= WIN_IDLE;
        else            state <= state_d;
    end

    // A window closes on the next start (possibly early) or after SPS samples
    always_comb begin
        state_d = state;
        load_c  = 1'b0;
        add_c   = 1'b0;
        dump_c  = 1'b0;
        case (state)
            WIN_IDLE: begin
                if (s1_start) begin
                    load_c  = 1'b1;
                    state_d = WIN_ACC;
                end
            end
            WIN_ACC: begin
                dump_c = s1_start || (win_len == LEN_W'(SPS));
                if (s1_start)                      load_c  = 1'b1;
                else if (win_len == LEN_W'(SPS))   state_d = WIN_IDLE;
                else                               add_c   = 1'b1;
            end
            default: state_d = WIN_IDLE;
        endcase
    end

    // Stage 2: integrate; sideband is latched from the window-start sample
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            acc_i    <= '0;
            acc_q    <= '0;
            win_len  <= '0;
            sym_vld  <= 1'b0;
            sym_last <= 1'b0;
            sym_bpsk <= 1'b0;
        end else if (load_c) begin
            acc_i    <= ACC_W'(y_i);
            acc_q    <= ACC_W'(y_q);
            win_len  <= LEN_W'(1);
            sym_vld  <= s1_vld;
            sym_last <= s1_last;
            sym_bpsk <= s1_bpsk;
        end else if (add_c) begin
            acc_i   <= acc_i + ACC_W'(y_i);
            acc_q   <= acc_q + ACC_W'(y_q);
            win_len <= win_len + LEN_W'(1);
        end
    end

    psk_slicer #(.ACC_W(ACC_W)) u_slicer (
        .acc_i   (acc_i),
        .acc_q   (acc_q),
        .is_bpsk (sym_bpsk),
        .bits_c  (bits_c)
    );

    assign dec_c     = dump_c && sym_vld;
    assign blocked_c = data.tvalid && !data.tready;

    // Output register: a decision arriving while the held one is stalled is dropped
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            data.tvalid <= 1'b0;
            data.tdata  <= '0;
            data.tlast  <= 1'b0;
            data.tuser  <= 1'b0;
            ovf         <= 1'b0;
`ifdef PSK_DEMOD_SOFT_EN
            data.soft_I <= '0;
            data.soft_Q <= '0;
`endif
        end else if (dec_c && blocked_c) begin
            ovf <= 1'b1;
        end else if (dec_c) begin
            data.tvalid <= 1'b1;
            data.tdata  <= TDATA_W'(bits_c);
            data.tlast  <= sym_last;
            data.tuser  <= sym_bpsk;
`ifdef PSK_DEMOD_SOFT_EN
            data.soft_I <= acc_i;
            data.soft_Q <= acc_q;
`endif
        end else if (data.tvalid && data.tready) begin
            data.tvalid <= 1'b0;
        end
    end

endmodule
